// File: rtl/eval_sequencer.sv
// Byte-driven stimulus/response sequencer: assemble a stimulus word from received bytes,
// settle, capture DEPTH responses, stream them out bytewise. Optional RECV timeout: EVAL_SEQUENCER_RX_TIMEOUT_EN.
module eval_sequencer #(
    parameter int IN_WIDTH       = 8,
    parameter int OUT_WIDTH      = 8,
    parameter int DEPTH          = 256,
    parameter int SETTLE_CYCLES  = 4,
    parameter int SAMPLE_DIV     = 1,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                 iClock,
    input  logic                 iReset,
    input  logic                 iRxDone,
    input  logic [7:0]           iRxData,
    output logic                 oTxSend,
    output logic [7:0]           oTxData,
    input  logic                 iTxDone,
    output logic [IN_WIDTH-1:0]  oStimulus,
    input  logic [OUT_WIDTH-1:0] iResponse,
    output logic                 oBusy,
    output logic                 oDone,
    output logic [2:0]           oState
);
    // state    | meaning
    // IDLE     | wait for first stimulus byte
    // RECV     | collect remaining stimulus bytes
    // SETTLE   | stimulus applied, wait SETTLE_CYCLES
    // SAMPLE   | capture DEPTH responses every SAMPLE_DIV clocks
    // SEND     | present one response byte
    // WAIT_TX  | wait for transmitter acknowledge
    localparam int BYTES_IN  = (IN_WIDTH + 7) / 8;
    localparam int BYTES_OUT = (OUT_WIDTH + 7) / 8;
    localparam int ADDR_W    = $clog2(DEPTH);
    localparam int TOTAL     = DEPTH * BYTES_OUT;
    localparam int BCNT_W    = $clog2(TOTAL + 1);
    localparam int LANE_W    = (BYTES_IN > 1) ? $clog2(BYTES_IN) : 1;
    localparam int OLANE_W   = (BYTES_OUT > 1) ? $clog2(BYTES_OUT) : 1;

    if (IN_WIDTH < 1 || IN_WIDTH > 32 || OUT_WIDTH < 1 || OUT_WIDTH > 32 || DEPTH < 2 ||
        DEPTH > 65536 || SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 || SAMPLE_DIV < 1 ||
        SAMPLE_DIV > 65535 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("eval_sequencer: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RECV    = 3'd1,
        S_SETTLE  = 3'd2,
        S_SAMPLE  = 3'd3,
        S_SEND    = 3'd4,
        S_WAIT_TX = 3'd5
    } state_t;

    state_t                 r_state, w_next;
    logic [BYTES_IN*8-1:0]  r_asm, w_asm_next;
    logic [LANE_W-1:0]      r_lane;
    logic [IN_WIDTH-1:0]    r_stim;
    logic [7:0]             r_set;
    logic [15:0]            r_div;
    logic [ADDR_W-1:0]      r_addr;
    logic [OLANE_W-1:0]     r_olane;
    logic [BCNT_W-1:0]      r_bcnt;
    logic                   r_done;
    logic [OUT_WIDTH-1:0]   r_mem [DEPTH];
    logic [BYTES_OUT*8-1:0] w_word;
    logic w_last_lane, w_last_addr, w_last_byte, w_wr, w_enter_settle, w_tmo_expire;

    assign w_last_lane    = (int'(r_lane) == BYTES_IN - 1);
    assign w_last_addr    = (r_addr == ADDR_W'(DEPTH - 1));
    assign w_last_byte    = (r_bcnt == BCNT_W'(TOTAL - 1));
    assign w_wr           = (r_state == S_SAMPLE) && (r_div == 16'd0);
    assign w_enter_settle = (w_next == S_SETTLE) && (r_state != S_SETTLE);

`ifdef EVAL_SEQUENCER_RX_TIMEOUT_EN
    logic [31:0] r_tmo;
    assign w_tmo_expire = (r_state == S_RECV) && !iRxDone && (r_tmo == 32'd0);

    // Reloaded outside RECV so the count is full on entry, and on every byte inside it
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset)
            r_tmo <= '0;
        else if (r_state != S_RECV || iRxDone)
            r_tmo <= 32'(TIMEOUT_CYCLES - 1);
        else if (r_tmo != 32'd0)
            r_tmo <= r_tmo - 1'b1;
    end
`else
    assign w_tmo_expire = 1'b0;
`endif

    always_comb begin
        w_asm_next = r_asm;
        w_asm_next[int'(r_lane)*8 +: 8] = iRxData;
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (iRxDone) w_next = (BYTES_IN > 1) ? S_RECV : S_SETTLE;
            S_RECV:    if (iRxDone && w_last_lane) w_next = S_SETTLE;
                       else if (w_tmo_expire)      w_next = S_IDLE;
            S_SETTLE:  if (r_set == 8'd0) w_next = S_SAMPLE;
            S_SAMPLE:  if (w_wr && w_last_addr) w_next = S_SEND;
            S_SEND:    w_next = S_WAIT_TX;
            S_WAIT_TX: if (iTxDone) w_next = w_last_byte ? S_IDLE : S_SEND;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_asm   <= '0;
            r_lane  <= '0;
            r_stim  <= '0;
            r_set   <= '0;
            r_div   <= '0;
            r_addr  <= '0;
            r_olane <= '0;
            r_bcnt  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_RECV: begin
                    if (iRxDone) begin
                        r_asm  <= w_asm_next;
                        r_lane <= r_lane + 1'b1;
                    end else if (w_tmo_expire) begin
                        r_asm  <= '0;
                        r_lane <= '0;
                    end
                end
                S_SETTLE: if (r_set != 8'd0) r_set <= r_set - 1'b1;
                S_SAMPLE: begin
                    if (w_wr) begin
                        if (w_last_addr) begin
                            r_addr  <= '0;
                            r_olane <= '0;
                            r_bcnt  <= '0;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                            r_div  <= 16'(SAMPLE_DIV - 1);
                        end
                    end else begin
                        r_div <= r_div - 1'b1;
                    end
                end
                S_WAIT_TX: begin
                    if (iTxDone) begin
                        if (w_last_byte) begin
                            r_done  <= 1'b1;
                            r_bcnt  <= '0;
                            r_addr  <= '0;
                            r_olane <= '0;
                        end else begin
                            r_bcnt <= r_bcnt + 1'b1;
                            if (int'(r_olane) == BYTES_OUT - 1) begin
                                r_olane <= '0;
                                r_addr  <= r_addr + 1'b1;
                            end else begin
                                r_olane <= r_olane + 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
            // Stimulus takes the word including the byte arriving this cycle
            if (w_enter_settle) begin
                r_stim <= w_asm_next[IN_WIDTH-1:0];
                r_lane <= '0;
                r_set  <= 8'(SETTLE_CYCLES - 1);
                r_div  <= '0;
                r_addr <= '0;
            end
        end
    end

    always_ff @(posedge iClock) begin
        if (w_wr) r_mem[r_addr] <= iResponse;
    end

    assign w_word    = (BYTES_OUT*8)'(r_mem[r_addr]);
    assign oTxSend   = (r_state == S_SEND);
    assign oTxData   = (r_state == S_SEND) ? w_word[int'(r_olane)*8 +: 8] : 8'h00;
    assign oStimulus = r_stim;
    assign oBusy     = (r_state != S_IDLE);
    assign oDone     = r_done;
    assign oState    = r_state;
endmodule

// File: tb/tb_eval_sequencer.sv
// Directed bench for eval_sequencer: three parameterisations sharing clock/reset, selected by sel.
module tb_eval_sequencer;
    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] sel = 2'd0;
    logic       rxdone = 1'b0, txdone = 1'b0;
    logic [7:0] rxdata = 8'h00;
    logic [7:0] fr = 8'h00;
    always @(posedge clk) fr <= fr + 8'd1;

    logic a_send, a_busy, a_done; logic [7:0] a_data, a_stim, a_resp; logic [2:0] a_state;
    logic b_send, b_busy, b_done; logic [7:0] b_data; logic [11:0] b_stim; logic [9:0] b_resp; logic [2:0] b_state;
    logic c_send, c_busy, c_done; logic [7:0] c_data; logic [15:0] c_stim; logic [2:0] c_state;
    assign a_resp = ~a_stim;
    assign b_resp = ~b_stim[9:0];

    eval_sequencer u_a (
        .iClock(clk), .iReset(rst), .iRxDone(rxdone && sel == 2'd0), .iRxData(rxdata),
        .oTxSend(a_send), .oTxData(a_data), .iTxDone(txdone && sel == 2'd0),
        .oStimulus(a_stim), .iResponse(a_resp), .oBusy(a_busy), .oDone(a_done), .oState(a_state));

    eval_sequencer #(.IN_WIDTH(12), .OUT_WIDTH(10), .DEPTH(4)) u_b (
        .iClock(clk), .iReset(rst), .iRxDone(rxdone && sel == 2'd1), .iRxData(rxdata),
        .oTxSend(b_send), .oTxData(b_data), .iTxDone(txdone && sel == 2'd1),
        .oStimulus(b_stim), .iResponse(b_resp), .oBusy(b_busy), .oDone(b_done), .oState(b_state));

    eval_sequencer #(.IN_WIDTH(16), .OUT_WIDTH(8), .DEPTH(4), .SAMPLE_DIV(3), .TIMEOUT_CYCLES(100)) u_c (
        .iClock(clk), .iReset(rst), .iRxDone(rxdone && sel == 2'd2), .iRxData(rxdata),
        .oTxSend(c_send), .oTxData(c_data), .iTxDone(txdone && sel == 2'd2),
        .oStimulus(c_stim), .iResponse(fr), .oBusy(c_busy), .oDone(c_done), .oState(c_state));

    logic sel_send, sel_busy, sel_done; logic [7:0] sel_data; logic [15:0] sel_stim; logic [2:0] sel_state;
    always_comb begin
        case (sel)
            2'd0: begin sel_send = a_send; sel_busy = a_busy; sel_done = a_done; sel_data = a_data;
                        sel_stim = {8'h00, a_stim}; sel_state = a_state; end
            2'd1: begin sel_send = b_send; sel_busy = b_busy; sel_done = b_done; sel_data = b_data;
                        sel_stim = {4'h0, b_stim}; sel_state = b_state; end
            default: begin sel_send = c_send; sel_busy = c_busy; sel_done = c_done; sel_data = c_data;
                        sel_stim = c_stim; sel_state = c_state; end
        endcase
    end

    int dcnt = 0;
    always @(posedge clk) if (sel_done) dcnt <= dcnt + 1;

    int checks = 0, failures = 0;
    logic [7:0] byte_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rxdata = b; rxdone = 1'b1;
        tick(1);
        rxdone = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int maxc);
        int w = 0;
        while (sel_state !== s && w < maxc) begin tick(1); w++; end
        chk(tag, 32'(sel_state), 32'(s));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(sel_state), 0);
        chk({tag, "_stim"},  32'(sel_stim), 0);
        chk({tag, "_busy"},  32'(sel_busy), 0);
        chk({tag, "_send"},  32'(sel_send), 0);
        chk({tag, "_data"},  32'(sel_data), 0);
        chk({tag, "_done"},  32'(sel_done), 0);
    endtask

    // Acknowledge n bytes; rnd gives 0..20 extra cycles of latency, inj adds stray pulses in SEND
    task automatic collect(input int n, input bit rnd, input bit inj);
        int w, d;
        byte_q.delete();
        for (int k = 0; k < n; k++) begin
            w = 0;
            while (sel_send !== 1'b1 && w < 400) begin tick(1); w++; end
            if (sel_send !== 1'b1) begin
                chk("tx_send_wait", 32'(sel_send), 1);
                return;
            end
            byte_q.push_back(sel_data);
            if (inj && k == 1) rxdone = 1'b1;
            if (inj && k == 3) txdone = 1'b1;
            d = rnd ? int'($urandom_range(0, 20)) : 0;
            repeat (1 + d) begin tick(1); rxdone = 1'b0; txdone = 1'b0; end
            txdone = 1'b1;
            tick(1);
            txdone = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, bad;
        #2 rst = 1'b1;
        #3;
        check_reset_outputs("por");
        @(posedge clk); #1;
        rst = 1'b0;
        tick(1);

        // Reset during SAMPLE, then during WAIT_TX
        sel = 2'd0;
        d0 = dcnt;
        rx_byte(8'h11);
        chk("a_stim_pre", 32'(sel_stim), 32'h11);
        wait_state("a_to_sample", 3'd3, 20);
        rst = 1'b1; #1;
        check_reset_outputs("rst_sample");
        rst = 1'b0;
        tick(1);
        rx_byte(8'h22);
        wait_state("a_to_waittx", 3'd5, 400);
        rst = 1'b1; #1;
        check_reset_outputs("rst_waittx");
        rst = 1'b0;
        tick(4);
        chk("no_done_after_reset", 32'(dcnt), 32'(d0));

        // Default build: stimulus 0x5A, response ~stimulus
        d0 = dcnt;
        rx_byte(8'h5A);
        chk("a_stim_1cyc", 32'(sel_stim), 32'h5A);
        chk("a_settle_entry", 32'(sel_state), 2);
        tick(3);
        chk("a_settle_last", 32'(sel_state), 2);
        tick(1);
        chk("a_sample_entry", 32'(sel_state), 3);
        collect(256, 1'b0, 1'b0);
        chk("a_byte_count", 32'(byte_q.size()), 256);
        bad = 0;
        foreach (byte_q[i]) if (byte_q[i] !== 8'hA5) bad++;
        chk("a_bytes_not_A5", 32'(bad), 0);
        tick(3);
        chk("a_done_once", 32'(dcnt - d0), 1);
        chk("a_idle_after", 32'(sel_state), 0);
        chk("a_busy_after", 32'(sel_busy), 0);
        chk("a_stim_hold", 32'(sel_stim), 32'h5A);

        // 12-bit stimulus, 10-bit response, random ack latency and stray pulses
        sel = 2'd1;
        d0 = dcnt;
        rx_byte(8'h34);
        chk("b_recv", 32'(sel_state), 1);
        chk("b_stim_partial", 32'(sel_stim), 0);
        rx_byte(8'h12);
        chk("b_stim", 32'(sel_stim), 32'h234);
        wait_state("b_sample", 3'd3, 10);
        txdone = 1'b1;
        tick(1);
        txdone = 1'b0;
        collect(8, 1'b1, 1'b1);
        chk("b_byte_count", 32'(byte_q.size()), 8);
        for (int i = 0; i < 8 && i < byte_q.size(); i++)
            chk($sformatf("b_byte%0d", i), 32'(byte_q[i]), (i % 2 == 0) ? 32'hCB : 32'h01);
        tick(3);
        chk("b_done_once", 32'(dcnt - d0), 1);
        chk("b_extra_send", 32'(sel_send), 0);
        chk("b_stim_unchanged", 32'(sel_stim), 32'h234);

        // SAMPLE_DIV=3 against a free-running counter
        sel = 2'd2;
        d0 = dcnt;
        rx_byte(8'h34);
        rx_byte(8'h12);
        chk("c_stim", 32'(sel_stim), 32'h1234);
        collect(4, 1'b0, 1'b0);
        chk("c_byte_count", 32'(byte_q.size()), 4);
        for (int i = 0; i < 3 && i + 1 < byte_q.size(); i++)
            chk($sformatf("c_delta%0d", i), 32'(8'(byte_q[i+1] - byte_q[i])), 3);
        tick(3);
        chk("c_done_once", 32'(dcnt - d0), 1);

        // Partial word followed by silence
        rx_byte(8'h77);
        chk("c_recv", 32'(sel_state), 1);
        tick(99);
        chk("c_recv_99", 32'(sel_state), 1);
        tick(1);
`ifdef EVAL_SEQUENCER_RX_TIMEOUT_EN
        chk("c_timeout_idle", 32'(sel_state), 0);
        chk("c_timeout_stim", 32'(sel_stim), 32'h1234);
        rx_byte(8'hCD);
        rx_byte(8'hAB);
        chk("c_after_timeout_stim", 32'(sel_stim), 32'hABCD);
`else
        chk("c_no_timeout", 32'(sel_state), 1);
        chk("c_no_timeout_stim", 32'(sel_stim), 32'h1234);
        tick(50);
        chk("c_still_recv", 32'(sel_state), 1);
`endif
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
